conv_window_gen: RTL

Streaming 3x3 sliding-window generator that sits directly upstream of the 3x3 convolution unit. It accepts one raster-order pixel per cycle and buffers the two previous image rows in line buffers. Whenever a full 3x3 neighbourhood is available, it presents that neighbourhood as nine registered taps, which drive the convolution unit's `a00..a22` operand inputs. Windows are "valid" convolution only (no padding), with valid/ready backpressure on both sides.

---
 rtl/conv_window_gen.sv | 106 ++++++++++
 1 files changed

// File: rtl/conv_window_gen.sv
// Streaming 3x3 sliding-window generator: two line buffers plus a 3x3 tap register,
// raster-order input, valid-only windows, single output stage with valid/ready on both sides.
module conv_window_gen #(
  parameter int WIDTH = 9,
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic [WIDTH-1:0] w00,
  output logic [WIDTH-1:0] w01,
  output logic [WIDTH-1:0] w02,
  output logic [WIDTH-1:0] w10,
  output logic [WIDTH-1:0] w11,
  output logic [WIDTH-1:0] w12,
  output logic [WIDTH-1:0] w20,
  output logic [WIDTH-1:0] w21,
  output logic [WIDTH-1:0] w22
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

  logic [CW-1:0]    r_col;
  logic [RW-1:0]    r_row;
  logic [WIDTH-1:0] r_lb0 [IMG_W];
  logic [WIDTH-1:0] r_lb1 [IMG_W];
  logic [WIDTH-1:0] r_win [3][3];
  logic             r_valid;
  logic             r_last;

  logic             w_accept;
  logic             w_emit;
  logic             w_win_ok;
  logic             w_frame_end;
  logic [WIDTH-1:0] w_lb0_rd;
  logic [WIDTH-1:0] w_lb1_rd;

  assign in_ready    = !r_valid || out_ready;
  assign w_accept    = in_valid && in_ready;
  assign w_emit      = r_valid && out_ready;
  assign w_lb0_rd    = r_lb0[r_col];
  assign w_lb1_rd    = r_lb1[r_col];
  assign w_win_ok    = (r_row >= RW'(2)) && (r_col >= CW'(2));
  assign w_frame_end = (r_row == ROW_MAX) && (r_col == COL_MAX);

  // Line buffers are plain storage; old contents only reach invalid windows.
  always_ff @(posedge clk) begin
    if (!rst && w_accept) begin
      r_lb1[r_col] <= w_lb0_rd;
      r_lb0[r_col] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col   <= '0;
      r_row   <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      for (int x = 0; x < 3; x++) begin
        for (int y = 0; y < 3; y++) begin
          r_win[x][y] <= '0;
        end
      end
    end else if (w_accept) begin
      for (int x = 0; x < 3; x++) begin
        r_win[x][0] <= r_win[x][1];
        r_win[x][1] <= r_win[x][2];
      end
      r_win[0][2] <= w_lb1_rd;
      r_win[1][2] <= w_lb0_rd;
      r_win[2][2] <= in_data;
      r_valid     <= w_win_ok;
      r_last      <= w_frame_end;
      if (r_col == COL_MAX) begin
        r_col <= '0;
        r_row <= (r_row == ROW_MAX) ? '0 : r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end else if (w_emit) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign out_last  = r_last;
  assign w00 = r_win[0][0];
  assign w01 = r_win[0][1];
  assign w02 = r_win[0][2];
  assign w10 = r_win[1][0];
  assign w11 = r_win[1][1];
  assign w12 = r_win[1][2];
  assign w20 = r_win[2][0];
  assign w21 = r_win[2][1];
  assign w22 = r_win[2][2];

endmodule
